// File: rtl/ram_burst_writer_if.sv
// Stream-in / RAM-write-out bundle for ram_burst_writer.
// The engine takes the slave modport; the producer/RAM side takes master.
interface ram_burst_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_wr_en, o_addr, o_data
  );

  modport master (
    output i_valid, i_data,
    input  o_ready, o_wr_en, o_addr, o_data
  );
endinterface

// File: rtl/ram_burst_writer.sv
// Burst write engine: accepts i_len stream words, writes them to RAM at base+k.
// Define RAM_WR_WRAP_EN to drop the range check and let addresses wrap.
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | accepting beats, one registered write per accepted beat
// DRAIN | last write (or none) on the port; o_done/o_err issued next
module ram_burst_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_base_addr,
  input  logic [LEN_W-1:0]   i_len,
  ram_burst_writer_if.slave  bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [LEN_W-1:0]   o_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  rem_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              err_pend_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              err_q;
  logic [LEN_W-1:0]  count_q;
  logic              range_bad;

`ifdef RAM_WR_WRAP_EN
  assign range_bad = 1'b0;
`else
  // Widened so base+len can never overflow before the compare.
  localparam int SUM_W = ADDR_W + LEN_W + 1;
  logic [SUM_W-1:0] end_w;
  logic [SUM_W-1:0] lim_w;
  assign end_w     = SUM_W'(i_base_addr) + SUM_W'(i_len);
  assign lim_w     = SUM_W'(1) << ADDR_W;
  assign range_bad = (end_w > lim_w);
`endif

  assign bus.o_ready = (state_q == RUN);
  assign bus.o_wr_en = wr_en_q;
  assign bus.o_addr  = addr_q;
  assign bus.o_data  = data_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_count     = count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      ptr_q      <= '0;
      err_pend_q <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            ptr_q      <= i_base_addr;
            rem_q      <= i_len;
            count_q    <= '0;
            err_pend_q <= range_bad;
            state_q    <= ((i_len != '0) && !range_bad) ? RUN : DRAIN;
          end
        end
        RUN: begin
          if (bus.i_valid) begin
            wr_en_q <= 1'b1;
            addr_q  <= ptr_q;
            data_q  <= bus.i_data;
            ptr_q   <= ptr_q + ADDR_W'(1);
            rem_q   <= rem_q - LEN_W'(1);
            count_q <= count_q + LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          done_q  <= 1'b1;
          err_q   <= err_pend_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_writer.sv
// Self-checking bench for ram_burst_writer: randomized bursts against a
// queue-based model of addresses, data and completion timing.
module tb_ram_burst_writer;

`ifdef RAM_WR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_base_addr = '0;
  logic [7:0] i_len = '0;
  logic       o_busy, o_done, o_err;
  logic [7:0] o_count;

  ram_burst_writer_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  ram_burst_writer #(.DATA_W(8), .ADDR_W(8), .LEN_W(8)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  wr_t  wr_q[$];
  int   done_q[$];
  logic last_err;
  logic [7:0] last_cnt;
  bit   pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample everything the previous rising edge produced.
  task automatic step();
    wr_t w;
    @(negedge i_clk);
    cyc++;
    if (bus.o_wr_en === 1'b1) begin
      w.c = cyc;
      w.a = 32'(bus.o_addr);
      w.d = 32'(bus.o_data);
      wr_q.push_back(w);
    end
    if (o_done === 1'b1) begin
      done_q.push_back(cyc);
      last_err = o_err;
      last_cnt = o_count;
    end
  endtask

  // Issues a start at the current negedge (engine must be idle) and returns in
  // the cycle o_done is observed, so a following call starts in the done cycle.
  task automatic run_burst(input int base, input int len, input int vmode, input bit mid_start);
    int  words[$];
    int  acc[$];
    bit  bad, v, mid_sent;
    int  exp_n, start_cyc, beats, it, exp_done;
    wr_q.delete();
    done_q.delete();
    for (int k = 0; k < len; k++) words.push_back(int'($urandom_range(0, 255)));
    bad      = !WRAP && ((base + len) > 256);
    exp_n    = bad ? 0 : len;
    beats    = 0;
    it       = 0;
    mid_sent = 1'b0;

    i_start     = 1'b1;
    i_base_addr = 8'(base);
    i_len       = 8'(len);
    bus.i_valid = 1'b0;
    start_cyc   = cyc;
    step();
    i_start     = 1'b0;
    i_base_addr = 8'($urandom);
    i_len       = 8'($urandom);
    chk("busy_after_start", 32'(o_busy), 32'd1);
    chk("count_cleared", 32'(o_count), 32'd0);
    chk("no_done_after_start", 32'(o_done), 32'd0);

    while (beats < exp_n && it < 300) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = pat[it % 6];
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (mid_start && beats == 2 && !mid_sent) begin
        i_start     = 1'b1;
        i_base_addr = 8'h40;
        i_len       = 8'd3;
        mid_sent    = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      chk("ready_in_run", 32'(bus.o_ready), 32'd1);
      bus.i_valid = v;
      bus.i_data  = 8'(words[beats]);
      if (v) begin
        acc.push_back(cyc);
        beats++;
      end
      step();
      it++;
    end
    i_start     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 8'($urandom);
    chk("beats_accepted", 32'(beats), 32'(exp_n));
    chk("ready_low_drain", 32'(bus.o_ready), 32'd0);
    chk("busy_in_drain", 32'(o_busy), 32'd1);

    it = 0;
    while (done_q.size() == 0 && it < 10) begin
      step();
      it++;
    end
    exp_done = (exp_n > 0) ? acc[exp_n-1] + 2 : start_cyc + 2;
    chk("done_pulses", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      chk("done_cycle", 32'(done_q[0] - start_cyc), 32'(exp_done - start_cyc));
      chk("err_at_done", 32'(last_err), 32'(bad));
      chk("count_at_done", 32'(last_cnt), 32'(exp_n));
      chk("busy_at_done", 32'(o_busy), 32'd0);
    end
    chk("write_count", 32'(wr_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wr_q.size(); i++) begin
      chk("write_latency", 32'(wr_q[i].c - acc[i]), 32'd1);
      chk("write_addr", wr_q[i].a, 32'((base + i) % 256));
      chk("write_data", wr_q[i].d, 32'(words[i]));
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    step();
    step();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    i_rst_n = 1'b1;
    step();

    run_burst(8'h10, 4, 0, 1'b0);
    run_burst(8'h10, 4, 1, 1'b0);
    run_burst(8'h33, 0, 0, 1'b0);
    run_burst(8'hFE, 4, 0, 1'b0);
    run_burst(8'h80, 6, 2, 1'b1);
    run_burst(8'h05, 3, 0, 1'b0);
    step();

    // Reset after two of four beats.
    i_start     = 1'b1;
    i_base_addr = 8'h20;
    i_len       = 8'd4;
    step();
    i_start     = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h5A;
    step();
    bus.i_data  = 8'hA5;
    step();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.o_ready), 32'd0);
    chk("mid_rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    chk("mid_rst_addr", 32'(bus.o_addr), 32'd0);
    chk("mid_rst_data", 32'(bus.o_data), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    chk("mid_rst_err", 32'(o_err), 32'd0);
    chk("mid_rst_count", 32'(o_count), 32'd0);
    bus.i_valid = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    done_q.delete();
    step();
    step();
    step();
    chk("no_done_after_abort", 32'(done_q.size()), 32'd0);
    chk("idle_after_abort", 32'(o_busy), 32'd0);

    run_burst(8'h60, 5, 2, 1'b0);
    for (int n = 0; n < 8; n++) begin
      run_burst(int'($urandom_range(0, 255)), int'($urandom_range(0, 20)), 2, 1'b0);
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
